// File: rtl/phy_reg_free_list.sv
// ---------------------------------------------------------------------------
// phy_reg_free_list
//   Circular free list of physical register numbers that feeds rename.
//   After reset it loads register numbers 0..INITIAL_LENGTH-1, POP_WIDTH per
//   cycle, then raises ready. In RUN it hands out up to POP_WIDTH entries per
//   cycle from head and takes back up to PUSH_WIDTH released entries at tail.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   pop         per-port allocation request (compacted onto head, head+1, ..)
//   poppedData  register number per pop port, combinational from head
//   push        per-port release request (compacted onto tail, tail+1, ..)
//   pushedData  released register number per push port
//   count       number of valid entries
//   ready       set once initialisation has completed
//   error       sticky flag: an underflowing pop group or overflowing push
//               group was dropped
// ---------------------------------------------------------------------------
module phy_reg_free_list #(
  parameter int SIZE           = 64,
  parameter int ENTRY_BIT_SIZE = 6,
  parameter int PUSH_WIDTH     = 2,
  parameter int POP_WIDTH      = 2,
  parameter int INITIAL_LENGTH = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [POP_WIDTH-1:0]                 pop,
  output logic [POP_WIDTH*ENTRY_BIT_SIZE-1:0]  poppedData,
  input  logic [PUSH_WIDTH-1:0]                push,
  input  logic [PUSH_WIDTH*ENTRY_BIT_SIZE-1:0] pushedData,
  output logic [$clog2(SIZE+1)-1:0]            count,
  output logic                                 ready,
  output logic                                 error
);

  localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W = $clog2(SIZE+1);

  typedef enum logic {INIT, RUN} stateT;

  stateT                     state;
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic [CNT_W-1:0]          initPtr;
  logic [ENTRY_BIT_SIZE-1:0] mem [SIZE];

  int unsigned               numPop;
  int unsigned               numPush;
  int unsigned               effPop;
  int unsigned               effPush;
  int unsigned               initStep;
  logic                      popOk;
  logic                      pushOk;
  logic [PTR_W-1:0]          pushAddr [PUSH_WIDTH];

  // Pointer advance with an explicit compare-and-subtract so SIZE need not be
  // a power of two. inc never exceeds SIZE, so one subtraction is enough.
  function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] ptr,
                                               input int unsigned       inc);
    int unsigned sum;
    sum = 32'(ptr) + inc;
    if (sum >= int'(SIZE))
      sum = sum - int'(SIZE);
    return sum[PTR_W-1:0];
  endfunction

  // Request decode. Overflow is judged after the pops of the same cycle have
  // been accounted for, so a full list can pop and push in the same cycle.
  always_comb begin
    int unsigned remaining;
    numPop    = $countones(pop);
    numPush   = $countones(push);
    popOk     = (numPop <= 32'(count));
    effPop    = popOk ? numPop : 0;
    pushOk    = ((32'(count) - effPop + numPush) <= int'(SIZE));
    effPush   = pushOk ? numPush : 0;
    remaining = int'(INITIAL_LENGTH) - 32'(initPtr);
    initStep  = (remaining < int'(POP_WIDTH)) ? remaining : int'(POP_WIDTH);
  end

  // Pop ports: the j-th asserted port reads head+j; idle ports read
  // head+portIndex (don't-care to the consumer).
  always_comb begin
    int unsigned rank;
    int unsigned idx;
    rank       = 0;
    idx        = 0;
    poppedData = '0;
    for (int k = 0; k < POP_WIDTH; k++) begin
      if (pop[k]) begin
        idx  = rank;
        rank = rank + 1;
      end else begin
        idx  = k;
      end
      poppedData[k*ENTRY_BIT_SIZE +: ENTRY_BIT_SIZE] = mem[wrapAdd(head, idx)];
    end
  end

  // Push ports: the j-th asserted port writes tail+j.
  always_comb begin
    int unsigned rank;
    rank = 0;
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      pushAddr[i] = wrapAdd(tail, rank);
      if (push[i])
        rank = rank + 1;
    end
  end

  // Control state: pointers, occupancy, init progress, flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      initPtr <= '0;
      ready   <= 1'b0;
      error   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          tail    <= wrapAdd(tail, initStep);
          count   <= count + CNT_W'(initStep);
          initPtr <= initPtr + CNT_W'(initStep);
          if ((32'(initPtr) + initStep) == int'(INITIAL_LENGTH)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          head  <= wrapAdd(head, effPop);
          tail  <= wrapAdd(tail, effPush);
          count <= CNT_W'(32'(count) - effPop + effPush);
          if (!popOk || !pushOk)
            error <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Entry storage, never reset. During INIT entry initPtr+k gets value
  // initPtr+k (tail tracks initPtr there, so tail+k is the same slot).
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int k = 0; k < POP_WIDTH; k++) begin
        if (k < int'(initStep))
          mem[wrapAdd(tail, k)] <= ENTRY_BIT_SIZE'(32'(initPtr) + k);
      end
    end else if (pushOk) begin
      for (int i = 0; i < PUSH_WIDTH; i++) begin
        if (push[i])
          mem[pushAddr[i]] <= pushedData[i*ENTRY_BIT_SIZE +: ENTRY_BIT_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_phy_reg_free_list.sv
// ---------------------------------------------------------------------------
// tb_phy_reg_free_list
//   Two instances share one stimulus stream: the default 64-entry list and an
//   8-entry list initialised with 6 entries (wrap-around and underflow corner).
//   Each is tracked by a queue-based reference model; directed sequences add
//   literal expectations on top of the model checks.
// ---------------------------------------------------------------------------
module tb_phy_reg_free_list;

  localparam int E = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pop = '0;
  logic [1:0]  push = '0;
  logic [11:0] pushedData = '0;

  logic [11:0] pd64, pd8;
  logic [6:0]  cnt64;
  logic [3:0]  cnt8;
  logic        rdy64, rdy8, err64, err8;

  always #5 clk = ~clk;

  phy_reg_free_list dut64 (
    .clk(clk), .rst(rst), .pop(pop), .poppedData(pd64), .push(push),
    .pushedData(pushedData), .count(cnt64), .ready(rdy64), .error(err64)
  );

  phy_reg_free_list #(
    .SIZE(8), .ENTRY_BIT_SIZE(6), .PUSH_WIDTH(2), .POP_WIDTH(2), .INITIAL_LENGTH(6)
  ) dut8 (
    .clk(clk), .rst(rst), .pop(pop), .poppedData(pd8), .push(push),
    .pushedData(pushedData), .count(cnt8), .ready(rdy8), .error(err8)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model, index 0 = 64-entry list, 1 = 8-entry list.
  int q [2][$];
  bit mRdy [2];
  bit mErr [2];
  int loaded [2];

  function automatic int capOf(input int d);
    return (d != 0) ? 8 : 64;
  endfunction

  function automatic int initLenOf(input int d);
    return (d != 0) ? 6 : 64;
  endfunction

  function int cntOf(input int d);
    return (d != 0) ? int'(cnt8) : int'(cnt64);
  endfunction

  function int rdyOf(input int d);
    return (d != 0) ? int'(rdy8) : int'(rdy64);
  endfunction

  function int errOf(input int d);
    return (d != 0) ? int'(err8) : int'(err64);
  endfunction

  task automatic checkEq(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      mRdy[d]   = 1'b0;
      mErr[d]   = 1'b0;
      loaded[d] = 0;
    end
  endtask

  // One clock cycle: drive, check combinational pop data before the edge,
  // advance the model on the edge, check registered outputs after it.
  task automatic doCycle(input logic [1:0] p, input logic [1:0] u,
                         input logic [11:0] dat,
                         output logic [11:0] o64, output logic [11:0] o8);
    int np, nq, j, n;
    logic [11:0] pd;
    pop = p;
    push = u;
    pushedData = dat;
    @(negedge clk);
    o64 = pd64;
    o8  = pd8;
    np = $countones(p);
    nq = $countones(u);
    for (int d = 0; d < 2; d++) begin
      pd = (d != 0) ? o8 : o64;
      if (mRdy[d] && np <= q[d].size()) begin
        j = 0;
        for (int k = 0; k < 2; k++) begin
          if (p[k]) begin
            checkEq($sformatf("popData_L%0d_port%0d", capOf(d), k),
                    int'(pd[k*E +: E]), q[d][j]);
            j++;
          end
        end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!mRdy[d]) begin
        n = initLenOf(d) - loaded[d];
        if (n > 2) n = 2;
        for (int k = 0; k < n; k++) q[d].push_back(loaded[d] + k);
        loaded[d] += n;
        if (loaded[d] == initLenOf(d)) mRdy[d] = 1'b1;
      end else begin
        if (np > q[d].size()) mErr[d] = 1'b1;
        else repeat (np) void'(q[d].pop_front());
        if (q[d].size() + nq > capOf(d)) mErr[d] = 1'b1;
        else for (int i = 0; i < 2; i++) if (u[i]) q[d].push_back(int'(dat[i*E +: E]));
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checkEq($sformatf("count_L%0d", capOf(d)), cntOf(d), q[d].size());
      checkEq($sformatf("ready_L%0d", capOf(d)), rdyOf(d), int'(mRdy[d]));
      checkEq($sformatf("error_L%0d", capOf(d)), errOf(d), int'(mErr[d]));
    end
    pop = '0;
    push = '0;
  endtask

  // Reset asserted between edges; its effect must be visible immediately.
  task automatic resetDut();
    @(negedge clk);
    rst = 1'b0;
    #1;
    modelReset();
    checkEq("rstCount64", int'(cnt64), 0);
    checkEq("rstReady64", int'(rdy64), 0);
    checkEq("rstError64", int'(err64), 0);
    checkEq("rstCount8", int'(cnt8), 0);
    checkEq("rstReady8", int'(rdy8), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic initWait();
    int c;
    logic [11:0] o64, o8;
    c = 0;
    while (rdy64 !== 1'b1 && c < 100) begin
      doCycle(2'b00, 2'b00, 12'd0, o64, o8);
      c++;
    end
    checkEq("initLatency", c, 32);
    checkEq("initCount64", int'(cnt64), 64);
    checkEq("initError64", int'(err64), 0);
  endtask

  initial begin
    logic [11:0] o64, o8;
    logic [1:0] p, u;

    // Defaults + wrap on the small list
    resetDut();
    initWait();
    checkEq("initCount8", int'(cnt8), 6);
    doCycle(2'b11, 2'b11, {6'd6, 6'd5}, o64, o8);
    checkEq("t1_pop0", int'(o64[5:0]), 0);
    checkEq("t1_pop1", int'(o64[11:6]), 1);
    doCycle(2'b11, 2'b11, {6'd6, 6'd5}, o64, o8);
    checkEq("t1_pop2", int'(o64[5:0]), 2);
    checkEq("t1_pop3", int'(o64[11:6]), 3);
    checkEq("t3_count", int'(cnt8), 6);
    doCycle(2'b11, 2'b00, 12'd0, o64, o8);
    checkEq("t3_a0", int'(o8[5:0]), 4);
    checkEq("t3_a1", int'(o8[11:6]), 5);
    doCycle(2'b11, 2'b00, 12'd0, o64, o8);
    checkEq("t3_b0", int'(o8[5:0]), 5);
    checkEq("t3_b1", int'(o8[11:6]), 6);
    doCycle(2'b11, 2'b00, 12'd0, o64, o8);
    checkEq("t3_c0", int'(o8[5:0]), 5);
    checkEq("t3_c1", int'(o8[11:6]), 6);

    // Overflow on a full list: pop survives, push dropped
    resetDut();
    initWait();
    doCycle(2'b01, 2'b11, {6'd33, 6'd44}, o64, o8);
    checkEq("t5_pop0", int'(o64[5:0]), 0);
    checkEq("t5_count", int'(cnt64), 63);
    checkEq("t5_error", int'(err64), 1);

    // Reset mid-operation, sequence restarts at 0,1
    resetDut();
    initWait();
    doCycle(2'b11, 2'b00, 12'd0, o64, o8);
    checkEq("t6_pop0", int'(o64[5:0]), 0);
    checkEq("t6_pop1", int'(o64[11:6]), 1);

    // Sparse pop, then underflow on the small list
    resetDut();
    initWait();
    doCycle(2'b10, 2'b00, 12'd0, o64, o8);
    checkEq("t2_port1", int'(o64[11:6]), 0);
    checkEq("t2_count", int'(cnt64), 63);
    doCycle(2'b11, 2'b00, 12'd0, o64, o8);
    checkEq("t2_next0", int'(o64[5:0]), 1);
    checkEq("t2_next1", int'(o64[11:6]), 2);
    doCycle(2'b01, 2'b00, 12'd0, o64, o8);
    doCycle(2'b01, 2'b00, 12'd0, o64, o8);
    checkEq("t4_countBefore", int'(cnt8), 1);
    doCycle(2'b11, 2'b01, {6'd0, 6'd9}, o64, o8);
    checkEq("t4_count", int'(cnt8), 2);
    checkEq("t4_error", int'(err8), 1);
    doCycle(2'b01, 2'b00, 12'd0, o64, o8);
    checkEq("t4_oldHead", int'(o8[5:0]), 5);

    // Randomized traffic: pop-heavy phase then push-heavy phase
    resetDut();
    initWait();
    for (int n = 0; n < 600; n++) begin
      p = 2'($urandom_range(0, 3));
      u = 2'($urandom_range(0, 3));
      if (n < 300 && ($urandom % 3) != 0) u = 2'b00;
      if (n >= 300 && ($urandom % 3) != 0) p = 2'b00;
      doCycle(p, u, 12'($urandom), o64, o8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
